// File: rtl/rtsnoc_int_rx_mc_pkg.sv
// Shared definitions for the multi-channel NoC interrupt receiver:
// command codes, FSM states and header field helpers.
package rtsnoc_int_rx_mc_pkg;

   localparam int LOC_W = 3;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      CMD_UP    = 2'd1,
      CMD_DOWN  = 2'd2,
      CMD_PULSE = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_ACK
   } state_e;

   // Wide enough to carry NUM_INTS itself, so out-of-range channels are visible.
   function automatic int ch_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rtsnoc_int_rx_mc_if.sv
// RTSNoC router local-port bundle as seen from the interrupt bridge.
// master: the bridge; slave: the router.
interface rtsnoc_int_rx_mc_if #(
   parameter int BUS_W = 42
);
   logic [BUS_W-1:0] noc_din_o;
   logic             noc_wr_o;
   logic             noc_rd_o;
   logic [BUS_W-1:0] noc_dout_i;
   logic             noc_wait_i;
   logic             noc_nd_i;

   modport master (
      output noc_din_o, noc_wr_o, noc_rd_o,
      input  noc_dout_i, noc_wait_i, noc_nd_i
   );

   modport slave (
      input  noc_din_o, noc_wr_o, noc_rd_o,
      output noc_dout_i, noc_wait_i, noc_nd_i
   );
endinterface

// File: rtl/rtsnoc_int_rx_mc_chan.sv
// One interrupt line: level register plus a pulse down-counter.
// Command strobes take priority over the pulse timeout.
module rtsnoc_int_rx_mc_chan #(
   parameter int PULSE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic set_i,
   input  logic clr_i,
   input  logic pulse_i,
   output logic line_o
);
   localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);

   logic             line_q, line_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      line_d = line_q;
      cnt_d  = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) line_d = 1'b0;
      end
      if (set_i) begin
         line_d = 1'b1;
         cnt_d  = '0;
      end else if (clr_i) begin
         line_d = 1'b0;
         cnt_d  = '0;
      end else if (pulse_i) begin
         line_d = 1'b1;
         cnt_d  = CNT_LOAD;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         line_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
      end
   end

   assign line_o = line_q;

endmodule

// File: rtl/rtsnoc_int_rx_mc.sv
// NoC-to-interrupt bridge: pops command packets, drives NUM_INTS lines,
// optionally answers each command with an ack packet to its originator.
module rtsnoc_int_rx_mc
   import rtsnoc_int_rx_mc_pkg::*;
#(
   parameter int NOC_DATA_WIDTH    = 32,
   parameter int NOC_LOCAL_ADR     = 0,
   parameter int NOC_X             = 0,
   parameter int NOC_Y             = 0,
   parameter int SOC_SIZE_X        = 1,
   parameter int SOC_SIZE_Y        = 1,
   parameter int NUM_INTS          = 8,
   parameter int PULSE_CYCLES      = 4,
   parameter int ACK_EN            = 1,
   parameter int FILTER_ORIG       = 0,
   parameter int NOC_X_SRC         = 0,
   parameter int NOC_Y_SRC         = 0,
   parameter int NOC_LOCAL_ADR_SRC = 0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   output logic [NUM_INTS-1:0] int_o,
   rtsnoc_int_rx_mc_if.master  noc
);
   localparam int CH_W  = ch_width(NUM_INTS);
   localparam int DW    = NOC_DATA_WIDTH;
   localparam int HDR_W = SOC_SIZE_X + SOC_SIZE_Y + LOC_W;
   localparam int BUS_W = DW + 2 * HDR_W;

   localparam logic [HDR_W-1:0] OWN_HDR = {
      SOC_SIZE_X'(NOC_X), SOC_SIZE_Y'(NOC_Y), LOC_W'(NOC_LOCAL_ADR)};
   localparam logic [HDR_W-1:0] SRC_HDR = {
      SOC_SIZE_X'(NOC_X_SRC), SOC_SIZE_Y'(NOC_Y_SRC),
      LOC_W'(NOC_LOCAL_ADR_SRC)};
   localparam logic [CH_W-1:0] NI_C = CH_W'(NUM_INTS);

   state_e           state_q, state_d;
   logic [BUS_W-1:0] rx_q, rx_d;
   logic [BUS_W-1:0] din_q, din_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;

   logic [HDR_W-1:0]    rx_orig;
   cmd_e                rx_cmd;
   logic [CH_W-1:0]     rx_ch;
   logic                orig_ok;
   logic                reject;
   logic [DW-1:0]       ack_data;
   logic [NUM_INTS-1:0] set_v, clr_v, pls_v;
   logic                unused_ok;

   assign rx_orig = rx_q[BUS_W-1 -: HDR_W];
   assign rx_cmd  = cmd_e'(rx_q[1:0]);
   assign rx_ch   = rx_q[CH_W+1:2];
   assign orig_ok = (FILTER_ORIG == 0) || (rx_orig == SRC_HDR);
   assign reject  = !orig_ok || (rx_cmd == CMD_NOP) || (rx_ch >= NI_C);

   assign unused_ok = ^{rx_q[DW +: HDR_W], rx_q[DW-1:CH_W+2]};

   always_comb begin
      ack_data            = '0;
      ack_data[1:0]       = rx_cmd;
      ack_data[CH_W+1:2]  = rx_ch;
      ack_data[DW-1]      = reject;
   end

   always_comb begin
      set_v = '0;
      clr_v = '0;
      pls_v = '0;
      for (int i = 0; i < NUM_INTS; i++) begin
         if (state_q == ST_EXEC && !reject && rx_ch == CH_W'(i)) begin
            unique case (rx_cmd)
               CMD_UP:    set_v[i] = 1'b1;
               CMD_DOWN:  clr_v[i] = 1'b1;
               CMD_PULSE: pls_v[i] = 1'b1;
               default:   ;
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rx_d    = rx_q;
      din_d   = din_q;
      rd_d    = 1'b0;
      wr_d    = wr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (noc.noc_nd_i) begin
               rx_d    = noc.noc_dout_i;
               rd_d    = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            // foreign-origin packets are dropped silently
            if (ACK_EN != 0 && orig_ok) begin
               din_d   = {OWN_HDR, rx_orig, ack_data};
               wr_d    = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!noc.noc_wait_i) begin
               wr_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         rx_q    <= '0;
         din_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rx_q    <= rx_d;
         din_q   <= din_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign noc.noc_din_o = din_q;
   assign noc.noc_wr_o  = wr_q;
   assign noc.noc_rd_o  = rd_q;

   for (genvar g = 0; g < NUM_INTS; g++) begin : g_ch
      rtsnoc_int_rx_mc_chan #(
         .PULSE_CYCLES (PULSE_CYCLES)
      ) u_ch (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .set_i   (set_v[g]),
         .clr_i   (clr_v[g]),
         .pulse_i (pls_v[g]),
         .line_o  (int_o[g])
      );
   end

endmodule

// File: tb/tb_rtsnoc_int_rx_mc.sv
// Directed bench for rtsnoc_int_rx_mc: one plain instance, one with
// origin filtering; expected values are hand-computed packets.
module tb_rtsnoc_int_rx_mc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] int_a;
   logic [7:0] int_b;
   int         checks = 0;
   int         failures = 0;
   bit         mon_en = 1'b0;
   int         mon_ch = 0;
   int         hi_cnt = 0;

   always #5 clk = ~clk;

   rtsnoc_int_rx_mc_if #(.BUS_W(42)) ia ();
   rtsnoc_int_rx_mc_if #(.BUS_W(42)) ib ();

   rtsnoc_int_rx_mc #(
      .NOC_LOCAL_ADR (3),
      .NOC_X         (0),
      .NOC_Y         (1)
   ) u_dut_a (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .int_o   (int_a),
      .noc     (ia)
   );

   rtsnoc_int_rx_mc #(
      .NOC_LOCAL_ADR     (3),
      .NOC_X             (0),
      .NOC_Y             (1),
      .FILTER_ORIG       (1),
      .NOC_X_SRC         (1),
      .NOC_Y_SRC         (1),
      .NOC_LOCAL_ADR_SRC (4)
   ) u_dut_b (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .int_o   (int_b),
      .noc     (ib)
   );

   always @(negedge clk) begin
      if (!mon_en) hi_cnt <= 0;
      else hi_cnt <= hi_cnt + int'(int_a[mon_ch]);
   end

   function automatic logic [41:0] mk(
      input logic xo, input logic yo, input logic [2:0] lo,
      input logic xd, input logic yd, input logic [2:0] ld,
      input logic [31:0] d);
      return {xo, yo, lo, xd, yd, ld, d};
   endfunction

   // packets into A come from (1,0,2); A's acks go back there
   function automatic logic [41:0] pa(input logic [31:0] d);
      return mk(1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 3'd3, d);
   endfunction

   function automatic logic [41:0] ea(input logic [31:0] d);
      return mk(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 3'd2, d);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit sel, input logic [41:0] pkt);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      if (sel) begin
         ib.noc_dout_i = pkt;
         ib.noc_nd_i   = 1'b1;
      end else begin
         ia.noc_dout_i = pkt;
         ia.noc_nd_i   = 1'b1;
      end
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         seen = sel ? ib.noc_rd_o : ia.noc_rd_o;
      end
      ia.noc_nd_i = 1'b0;
      ib.noc_nd_i = 1'b0;
      chk("pop", 64'(seen), 64'd1);
   endtask

   task automatic run(input logic [41:0] pkt);
      push(1'b0, pkt);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      ia.noc_dout_i = '0;
      ia.noc_wait_i = 1'b0;
      ia.noc_nd_i   = 1'b0;
      ib.noc_dout_i = '0;
      ib.noc_wait_i = 1'b0;
      ib.noc_nd_i   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_int", 64'(int_a), 64'h0);
      chk("rst_wr", 64'(ia.noc_wr_o), 64'h0);
      chk("rst_rd", 64'(ia.noc_rd_o), 64'h0);
      chk("rst_din", 64'(ia.noc_din_o), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // UP ch5: one-cycle pop, line 5 set, ack data 0x15 back to (1,0,2)
      push(1'b0, pa(32'h15));
      chk("t1_int_pre", 64'(int_a), 64'h0);
      @(negedge clk);
      chk("t1_rd_once", 64'(ia.noc_rd_o), 64'h0);
      chk("t1_int", 64'(int_a), 64'h20);
      chk("t1_wr", 64'(ia.noc_wr_o), 64'h1);
      chk("t1_din", 64'(ia.noc_din_o), 64'(ea(32'h15)));
      @(negedge clk);
      chk("t1_wr_done", 64'(ia.noc_wr_o), 64'h0);

      // lone PULSE ch1 stays high exactly 4 cycles
      mon_ch = 1;
      mon_en = 1'b1;
      run(pa(32'h07));
      repeat (8) @(negedge clk);
      chk("t2_pulse_len", 64'(hi_cnt), 64'd4);
      mon_en = 1'b0;
      @(negedge clk);

      // back-to-back PULSE ch0, execs 3 cycles apart: 3 + 4 high
      mon_ch = 0;
      mon_en = 1'b1;
      push(1'b0, pa(32'h03));
      push(1'b0, pa(32'h03));
      repeat (10) @(negedge clk);
      chk("t2_restart_len", 64'(hi_cnt), 64'd7);
      mon_en = 1'b0;
      @(negedge clk);

      // PULSE on held-up ch5 keeps it high, then times out
      run(pa(32'h17));
      chk("t2_up_pulse_hi", 64'(int_a), 64'h20);
      repeat (6) @(negedge clk);
      chk("t2_up_pulse_lo", 64'(int_a), 64'h0);

      run(pa(32'h09));
      chk("up_ch2", 64'(int_a), 64'h04);
      run(pa(32'h0A));
      chk("down_ch2", 64'(int_a), 64'h0);
      run(pa(32'h1D));
      run(pa(32'h0D));
      chk("up_ch7_ch3", 64'(int_a), 64'h88);

      // channel 9 rejected
      push(1'b0, pa(32'h25));
      @(negedge clk);
      chk("t3_wr", 64'(ia.noc_wr_o), 64'h1);
      chk("t3_din", 64'(ia.noc_din_o), 64'(ea(32'h8000_0025)));
      @(negedge clk);
      chk("t3_int", 64'(int_a), 64'h88);

      // NOP rejected
      push(1'b0, pa(32'h10));
      @(negedge clk);
      chk("nop_din", 64'(ia.noc_din_o), 64'(ea(32'h8000_0010)));
      @(negedge clk);
      chk("nop_int", 64'(int_a), 64'h88);

      // router busy for 10 cycles; a pending packet waits
      ia.noc_wait_i = 1'b1;
      push(1'b0, pa(32'h19));
      @(negedge clk);
      chk("t4_wr", 64'(ia.noc_wr_o), 64'h1);
      ia.noc_dout_i = pa(32'h05);
      ia.noc_nd_i   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_wr_hold", 64'(ia.noc_wr_o), 64'h1);
         chk("t4_din_hold", 64'(ia.noc_din_o), 64'(ea(32'h19)));
         chk("t4_no_pop", 64'(ia.noc_rd_o), 64'h0);
      end
      ia.noc_wait_i = 1'b0;
      @(negedge clk);
      chk("t4_wr_done", 64'(ia.noc_wr_o), 64'h0);
      chk("t4_rd_idle", 64'(ia.noc_rd_o), 64'h0);
      @(negedge clk);
      chk("t4_pop_next", 64'(ia.noc_rd_o), 64'h1);
      ia.noc_nd_i = 1'b0;
      @(negedge clk);
      chk("t4_int", 64'(int_a), 64'hCA);
      @(negedge clk);

      // filtered instance: wrong origin popped and dropped
      push(1'b1, mk(1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 3'd3, 32'h01));
      @(negedge clk);
      chk("t5_no_ack", 64'(ib.noc_wr_o), 64'h0);
      chk("t5_int", 64'(int_b), 64'h0);
      @(negedge clk);
      chk("t5_no_ack2", 64'(ib.noc_wr_o), 64'h0);
      push(1'b1, mk(1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 3'd3, 32'h01));
      @(negedge clk);
      chk("t5_ok_wr", 64'(ib.noc_wr_o), 64'h1);
      chk("t5_ok_din", 64'(ib.noc_din_o),
          64'(mk(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3'd4, 32'h01)));
      chk("t5_ok_int", 64'(int_b), 64'h01);
      @(negedge clk);

      // all lines up, pulse one, reset while the ack is stalled
      run(pa(32'h01));
      run(pa(32'h09));
      run(pa(32'h11));
      run(pa(32'h15));
      chk("t6_all_up", 64'(int_a), 64'hFF);
      ia.noc_wait_i = 1'b1;
      push(1'b0, pa(32'h0F));
      @(negedge clk);
      chk("t6_in_ack", 64'(ia.noc_wr_o), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_int", 64'(int_a), 64'h0);
      chk("t6_rst_wr", 64'(ia.noc_wr_o), 64'h0);
      chk("t6_rst_rd", 64'(ia.noc_rd_o), 64'h0);
      chk("t6_rst_din", 64'(ia.noc_din_o), 64'h0);
      chk("t6_rst_int_b", 64'(int_b), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ia.noc_wait_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_no_retx", 64'(ia.noc_wr_o), 64'h0);
      run(pa(32'h01));
      chk("t6_idle_ok", 64'(int_a), 64'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
